// File: rtl/ps2_host_tx_if.sv
// Interface between a PS/2 command source and ps2_host_tx: command handshake plus the
// raw line inputs and open-drain pull-low enables.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_low;
  logic       ps2_data_low;
  logic       busy;
  logic       done;
  logic       error;

  // Requester side: issues commands and presents the sensed line levels.
  modport master (
    output tx_data, tx_start, ps2_clk_in, ps2_data_in,
    input  ps2_clk_low, ps2_data_low, busy, done, error
  );

  // Transmitter side.
  modport slave (
    input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
    output ps2_clk_low, ps2_data_low, busy, done, error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, device-clocked shift, ACK.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ_HZ    = 65_000_000,
  parameter int unsigned INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,       // 100 us
  parameter int unsigned TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1_000) * 15  // 15 ms
) (
  input  logic           clk,
  input  logic           rst,
  ps2_host_tx_if.slave   bus
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StShift,
    StAck,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic            clk_low_q, clk_low_d;
  logic            data_low_q, data_low_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall;
  logic wdog_expired;

  // Idle lines are high, so synchronisers reset high to avoid a phantom falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= bus.ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= bus.ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);

  logic [TmoW-1:0] wdog_q, wdog_d;

  // Held at zero until RTS, so RTS entry starts the count from zero.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == StIdle || state_q == StInhibit || fall) begin
      wdog_d = '0;
    end else if (wdog_q != TmoMax) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  assign wdog_expired = (state_q != StIdle) && (state_q != StInhibit) && (wdog_d == TmoMax);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        if (bus.tx_start) begin
          shift_d   = {1'b1, ~^bus.tx_data, bus.tx_data};
          busy_d    = 1'b1;
          clk_low_d = 1'b1;
          // Counts clock-low cycles already elapsed; clock releases one cycle after RTS entry.
          inh_cnt_d = InhW'(1);
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (inh_cnt_q >= InhLast) begin
          data_low_d = 1'b1;
          state_d    = StRts;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      StRts: begin
        clk_low_d = 1'b0;
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        if (fall) begin
          data_low_d = ~shift_q[bit_cnt_q];
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        if (fall) begin
          if (!data_sync_q) begin
            state_d = StWaitIdle;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      StWaitIdle: begin
        if (clk_sync_q && data_sync_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (wdog_expired) begin
      clk_low_d  = 1'b0;
      data_low_d = 1'b0;
      error_d    = 1'b1;
      busy_d     = 1'b0;
      state_d    = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      inh_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.ps2_clk_low  = clk_low_q;
  assign bus.ps2_data_low = data_low_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: table of frames against a PS/2 device model, plus reset-mid-frame,
// busy re-request and watchdog sequences.
module tb_ps2_host_tx;
  localparam int INH        = 6500;
  localparam int TB_TIMEOUT = 3000;
  localparam int H          = 12;  // device half clock period in system clocks
  localparam int MAX_CYC    = 95_000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Open-drain wired-AND of host and device pull-downs with pull-ups.
  assign bus.ps2_clk_in  = ~(bus.ps2_clk_low | dev_clk_low);
  assign bus.ps2_data_in = ~(bus.ps2_data_low | dev_data_low);

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        ack;
    int          repulse_at;
    logic [10:0] exp_bits;  // [0]=start, [8:1]=data, [9]=parity, [10]=stop
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt, err_cnt, rts_cyc;
  logic edge_ok;
  logic busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (cyc > MAX_CYC) begin
      $display("FAIL cycle_budget: got %0d cycles, expected below %0d", cyc, MAX_CYC);
      $fatal(1, "cycle budget exhausted");
    end
    if (bus.done) done_cnt++;
    if (bus.error) err_cnt++;
    if (busy_prev && !bus.busy) edge_ok = bus.done | bus.error;
    busy_prev = bus.busy;
  endtask

  task automatic start_tx(input logic [7:0] data, output int inh);
    done_cnt = 0;
    err_cnt  = 0;
    edge_ok  = 1'b0;
    rts_cyc  = -1;
    bus.tx_data  = data;
    bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    inh = 0;
    while (bus.ps2_clk_low && inh < INH + 100) begin
      inh++;
      if (bus.ps2_data_low && rts_cyc < 0) rts_cyc = cyc;
      step();
    end
  endtask

  task automatic run_frame(input logic [7:0] data, input logic ack, input int repulse_at,
                           output logic [10:0] bits, output int inh);
    start_tx(data, inh);
    repeat (H) step();
    bits[0] = bus.ps2_data_in;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      for (int i = 0; i < H; i++) begin
        if (k == repulse_at && i == 0) begin
          bus.tx_data  = 8'h55;
          bus.tx_start = 1'b1;
        end
        step();
        bus.tx_start = 1'b0;
      end
      bits[k] = bus.ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (H) step();
    end
    dev_data_low = ack;
    repeat (H) step();
    dev_clk_low = 1'b1;
    repeat (H) step();
    dev_clk_low = 1'b0;
    repeat (H) step();
    dev_data_low = 1'b0;
    for (int i = 0; i < 100 && bus.busy; i++) step();
    repeat (2) step();
  endtask

  initial begin
    logic [10:0] bits;
    int inh;

    vecs[0] = '{8'hF4, 1'b1, 0, 11'b1_0_11110100_0, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 0, 11'b1_1_11111111_0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 0, 11'b1_1_00000000_0, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 0, 11'b1_0_00000001_0, 1'b1, 1'b0};
    vecs[4] = '{8'hA5, 1'b0, 0, 11'b1_1_10100101_0, 1'b0, 1'b1};
    vecs[5] = '{8'h3C, 1'b1, 4, 11'b1_1_00111100_0, 1'b1, 1'b0};

    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    done_cnt = 0;
    err_cnt  = 0;
    edge_ok  = 1'b0;
    rts_cyc  = -1;

    repeat (3) step();
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_error", bus.error, 1'b0);
    check("reset_clk_low", bus.ps2_clk_low, 1'b0);
    check("reset_data_low", bus.ps2_data_low, 1'b0);
    rst = 1'b1;
    repeat (3) step();

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].data, vecs[v].ack, vecs[v].repulse_at, bits, inh);
      check($sformatf("v%0d_inhibit_len", v), inh, INH);
      check($sformatf("v%0d_bits", v), bits, vecs[v].exp_bits);
      check($sformatf("v%0d_done_pulses", v), done_cnt, vecs[v].exp_done);
      check($sformatf("v%0d_error_pulses", v), err_cnt, vecs[v].exp_err);
      check($sformatf("v%0d_busy_falls_with_pulse", v), edge_ok, 1'b1);
      check($sformatf("v%0d_busy_end", v), bus.busy, 1'b0);
      check($sformatf("v%0d_lines_released", v), {bus.ps2_clk_low, bus.ps2_data_low}, 2'b00);
    end

    // Asynchronous reset in the middle of SHIFT while the host drives d3=0 of 0xF4.
    start_tx(8'hF4, inh);
    repeat (H) step();
    for (int k = 1; k <= 4; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) step();
      if (k < 4) begin
        dev_clk_low = 1'b0;
        repeat (H) step();
      end
    end
    check("mid_shift_driving_d3", bus.ps2_data_low, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_clk_low", bus.ps2_clk_low, 1'b0);
    check("async_rst_data_low", bus.ps2_data_low, 1'b0);
    check("async_rst_busy", bus.busy, 1'b0);
    dev_clk_low = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    repeat (3) step();
    run_frame(8'hF4, 1'b1, 0, bits, inh);
    check("post_rst_bits", bits, 11'b1_0_11110100_0);
    check("post_rst_done", done_cnt, 1);
    check("post_rst_error", err_cnt, 0);

    // Device never clocks after request-to-send.
    start_tx(8'hF4, inh);
`ifdef PS2_TX_TIMEOUT_EN
    for (int i = 0; i < TB_TIMEOUT + 100 && !bus.error; i++) step();
    check("tmo_latency", cyc - rts_cyc, TB_TIMEOUT);
    check("tmo_error", bus.error, 1'b1);
    check("tmo_lines_released", {bus.ps2_clk_low, bus.ps2_data_low}, 2'b00);
    check("tmo_busy", bus.busy, 1'b0);
    repeat (3) step();
    check("tmo_error_pulses", err_cnt, 1);
    check("tmo_done_pulses", done_cnt, 0);
`else
    repeat (TB_TIMEOUT + 200) step();
    check("no_tmo_busy_held", bus.busy, 1'b1);
    check("no_tmo_no_error", err_cnt, 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
